// File: rtl/aoi21_reg_bank.sv
// WIDTH-lane AOI21 (QN = ~((IN1 & IN2) | IN3)) with a DEPTH-stage valid-qualified pipeline.
// Optional saturating QN toggle counter enabled by defining AOI21_BANK_TGLCNT_EN.
module aoi21_reg_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic [WIDTH-1:0] IN3,
  input  logic             VALID_IN,
  input  logic             EN,
  input  logic             CLR_CNT,
  output logic [WIDTH-1:0] QN,
  output logic             VALID_OUT,
  output logic [CNT_W-1:0] TGL_CNT
);

  logic [WIDTH-1:0] w_d0;
  logic [WIDTH-1:0] w_d [0:DEPTH-1];
  logic [DEPTH-1:0] w_v;
  logic [WIDTH-1:0] r_data [1:DEPTH];
  logic [DEPTH:1]   r_valid;

  assign w_d0 = ~((IN1 & IN2) | IN3);

  // Input side of each stage: index k feeds stage k+1.
  always_comb begin
    w_d[0] = w_d0;
    w_v[0] = VALID_IN;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      w_d[k] = r_data[k];
      w_v[k] = r_valid[k];
    end
  end

  // Valid always advances; data only captures valid words so bubbles never disturb QN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        r_data[k] <= '1;
      end
      r_valid <= '0;
    end else if (EN) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        r_valid[k] <= w_v[k-1];
        if (w_v[k-1]) begin
          r_data[k] <= w_d[k-1];
        end
      end
    end
  end

  assign QN        = r_data[DEPTH];
  assign VALID_OUT = r_valid[DEPTH];

`ifdef AOI21_BANK_TGLCNT_EN
  localparam int unsigned POP_W = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [WIDTH-1:0] w_diff;
  logic [POP_W-1:0] w_pop;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] r_cnt;

  // Bits that flip on QN when the word entering the last stage lands.
  assign w_diff = r_data[DEPTH] ^ w_d[DEPTH-1];

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + POP_W'(w_diff[i]);
    end
  end

  assign w_sum = SUM_W'(r_cnt) + SUM_W'(w_pop);

  // Clear wins over increment and ignores the stall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (CLR_CNT) begin
      r_cnt <= '0;
    end else if (EN && w_v[DEPTH-1]) begin
      r_cnt <= (w_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end
  end

  assign TGL_CNT = r_cnt;
`else
  logic w_unused_clr;

  assign w_unused_clr = CLR_CNT;
  assign TGL_CNT      = '0;
`endif

endmodule

// File: tb/tb_aoi21_reg_bank.sv
// Directed bench for aoi21_reg_bank: default instance, CNT_W=4 instance and DEPTH=1 instance
// share one stimulus set; counter expectations follow AOI21_BANK_TGLCNT_EN.
module tb_aoi21_reg_bank;

`ifdef AOI21_BANK_TGLCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] IN1 = '0;
  logic [7:0] IN2 = '0;
  logic [7:0] IN3 = '0;
  logic       VALID_IN = 1'b0;
  logic       EN = 1'b1;
  logic       CLR_CNT = 1'b0;

  logic [7:0]  m_qn, s_qn, o_qn;
  logic        m_v, s_v, o_v;
  logic [15:0] m_cnt, o_cnt;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  aoi21_reg_bank #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .IN1(IN1), .IN2(IN2), .IN3(IN3), .VALID_IN(VALID_IN),
    .EN(EN), .CLR_CNT(CLR_CNT), .QN(m_qn), .VALID_OUT(m_v), .TGL_CNT(m_cnt));

  aoi21_reg_bank #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) dut_sat (
    .CLK(CLK), .RST(RST), .IN1(IN1), .IN2(IN2), .IN3(IN3), .VALID_IN(VALID_IN),
    .EN(EN), .CLR_CNT(CLR_CNT), .QN(s_qn), .VALID_OUT(s_v), .TGL_CNT(s_cnt));

  aoi21_reg_bank #(.WIDTH(8), .DEPTH(1), .CNT_W(16)) dut_d1 (
    .CLK(CLK), .RST(RST), .IN1(IN1), .IN2(IN2), .IN3(IN3), .VALID_IN(VALID_IN),
    .EN(EN), .CLR_CNT(CLR_CNT), .QN(o_qn), .VALID_OUT(o_v), .TGL_CNT(o_cnt));

  function automatic logic [15:0] ec(input int unsigned v);
    return CNT_ON ? 16'(v) : 16'd0;
  endfunction

  function automatic logic [3:0] ec4(input int unsigned v);
    return CNT_ON ? 4'(v) : 4'd0;
  endfunction

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic v);
    IN1 = a; IN2 = b; IN3 = c; VALID_IN = v;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    set_in(8'h00, 8'h00, 8'h00, 1'b0);
    EN = 1'b1; CLR_CNT = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
    set_in(8'hF0, 8'hCC, 8'h01, 1'b1);
    step();
    set_in(8'h00, 8'h00, 8'h00, 1'b0);
    step();
    // Async assertion between edges must take effect without a clock.
    #2 RST = 1'b1;
    #1;
    checks++; if ({m_qn, m_v, m_cnt} !== {8'hFF, 1'b0, 16'd0}) begin errors++; $display("FAIL rst_async_main: got %h exp %h", {m_qn, m_v, m_cnt}, {8'hFF, 1'b0, 16'd0}); end
    checks++; if ({o_qn, o_v, o_cnt} !== {8'hFF, 1'b0, 16'd0}) begin errors++; $display("FAIL rst_async_d1: got %h exp %h", {o_qn, o_v, o_cnt}, {8'hFF, 1'b0, 16'd0}); end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({m_qn, m_v, m_cnt} !== {8'hFF, 1'b0, 16'd0}) begin errors++; $display("FAIL rst_idle%0d: got %h exp %h", i, {m_qn, m_v, m_cnt}, {8'hFF, 1'b0, 16'd0}); end
    end
    // In-flight word must be discarded by a reset pulse.
    set_in(8'hF0, 8'hCC, 8'h01, 1'b1);
    step();
    set_in(8'h00, 8'h00, 8'h00, 1'b0);
    #2 RST = 1'b1;
    #2 RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if ({m_qn, m_v, m_cnt} !== {8'hFF, 1'b0, 16'd0}) begin errors++; $display("FAIL rst_midflight%0d: got %h exp %h", i, {m_qn, m_v, m_cnt}, {8'hFF, 1'b0, 16'd0}); end
    end
  endtask

  task automatic test_single_word();
    do_reset();
    set_in(8'hF0, 8'hCC, 8'h01, 1'b1);
    step();
    set_in(8'h00, 8'h00, 8'h00, 1'b0);
    checks++; if ({m_qn, m_v, m_cnt} !== {8'hFF, 1'b0, 16'd0}) begin errors++; $display("FAIL sw_e1_main: got %h exp %h", {m_qn, m_v, m_cnt}, {8'hFF, 1'b0, 16'd0}); end
    checks++; if ({o_qn, o_v, o_cnt} !== {8'h3E, 1'b1, ec(3)}) begin errors++; $display("FAIL sw_e1_d1: got %h exp %h", {o_qn, o_v, o_cnt}, {8'h3E, 1'b1, ec(3)}); end
    step();
    checks++; if ({m_qn, m_v, m_cnt} !== {8'h3E, 1'b1, ec(3)}) begin errors++; $display("FAIL sw_e2_main: got %h exp %h", {m_qn, m_v, m_cnt}, {8'h3E, 1'b1, ec(3)}); end
    checks++; if ({s_qn, s_v, s_cnt} !== {8'h3E, 1'b1, ec4(3)}) begin errors++; $display("FAIL sw_e2_sat: got %h exp %h", {s_qn, s_v, s_cnt}, {8'h3E, 1'b1, ec4(3)}); end
    checks++; if ({o_qn, o_v, o_cnt} !== {8'h3E, 1'b0, ec(3)}) begin errors++; $display("FAIL sw_e2_d1: got %h exp %h", {o_qn, o_v, o_cnt}, {8'h3E, 1'b0, ec(3)}); end
    step();
    checks++; if ({m_qn, m_v, m_cnt} !== {8'h3E, 1'b0, ec(3)}) begin errors++; $display("FAIL sw_e3_main: got %h exp %h", {m_qn, m_v, m_cnt}, {8'h3E, 1'b0, ec(3)}); end
  endtask

  task automatic test_stall_bubble();
    do_reset();
    set_in(8'hF0, 8'hCC, 8'h01, 1'b1);
    step();
    set_in(8'h00, 8'h00, 8'h00, 1'b0);
    EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({m_qn, m_v, m_cnt} !== {8'hFF, 1'b0, 16'd0}) begin errors++; $display("FAIL stall_main%0d: got %h exp %h", i, {m_qn, m_v, m_cnt}, {8'hFF, 1'b0, 16'd0}); end
      checks++; if ({o_qn, o_v} !== {8'h3E, 1'b1}) begin errors++; $display("FAIL stall_d1_hold%0d: got %h exp %h", i, {o_qn, o_v}, {8'h3E, 1'b1}); end
    end
    EN = 1'b1;
    step();
    checks++; if ({m_qn, m_v, m_cnt} !== {8'h3E, 1'b1, ec(3)}) begin errors++; $display("FAIL stall_arrive: got %h exp %h", {m_qn, m_v, m_cnt}, {8'h3E, 1'b1, ec(3)}); end
    EN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if ({m_qn, m_v, m_cnt} !== {8'h3E, 1'b1, ec(3)}) begin errors++; $display("FAIL stall_vhold%0d: got %h exp %h", i, {m_qn, m_v, m_cnt}, {8'h3E, 1'b1, ec(3)}); end
    end
    EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      step();
      checks++; if ({m_qn, m_v, m_cnt} !== {8'h3E, 1'b0, ec(3)}) begin errors++; $display("FAIL bubble%0d: got %h exp %h", i, {m_qn, m_v, m_cnt}, {8'h3E, 1'b0, ec(3)}); end
    end
  endtask

  task automatic test_saturation();
    int unsigned sat_tab [5] = '{0, 8, 15, 15, 15};
    int unsigned main_tab [5] = '{0, 8, 16, 24, 32};
    logic [7:0] exp_q;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) set_in(8'h00, 8'h00, (i % 2 == 1) ? 8'hFF : 8'h00, 1'b1);
      else       set_in(8'h00, 8'h00, 8'h00, 1'b0);
      step();
      if (i >= 1) begin
        exp_q = ((i - 1) % 2 == 1) ? 8'h00 : 8'hFF;
        checks++; if ({s_qn, s_v, s_cnt} !== {exp_q, 1'b1, ec4(sat_tab[i-1])}) begin errors++; $display("FAIL sat_w%0d: got %h exp %h", i - 1, {s_qn, s_v, s_cnt}, {exp_q, 1'b1, ec4(sat_tab[i-1])}); end
        checks++; if ({m_qn, m_v, m_cnt} !== {exp_q, 1'b1, ec(main_tab[i-1])}) begin errors++; $display("FAIL wide_w%0d: got %h exp %h", i - 1, {m_qn, m_v, m_cnt}, {exp_q, 1'b1, ec(main_tab[i-1])}); end
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    set_in(8'hF0, 8'hCC, 8'h01, 1'b1);
    step();
    set_in(8'h00, 8'h00, 8'h00, 1'b0);
    CLR_CNT = 1'b1;
    step();
    checks++; if ({m_qn, m_v, m_cnt} !== {8'h3E, 1'b1, 16'd0}) begin errors++; $display("FAIL clr_prio: got %h exp %h", {m_qn, m_v, m_cnt}, {8'h3E, 1'b1, 16'd0}); end
    CLR_CNT = 1'b0;
    set_in(8'h00, 8'h00, 8'hFF, 1'b1);
    step();
    set_in(8'h00, 8'h00, 8'h00, 1'b0);
    step();
    checks++; if ({m_qn, m_v, m_cnt} !== {8'h00, 1'b1, ec(5)}) begin errors++; $display("FAIL clr_recount: got %h exp %h", {m_qn, m_v, m_cnt}, {8'h00, 1'b1, ec(5)}); end
    EN = 1'b0;
    CLR_CNT = 1'b1;
    step();
    checks++; if ({m_qn, m_v, m_cnt} !== {8'h00, 1'b1, 16'd0}) begin errors++; $display("FAIL clr_stalled: got %h exp %h", {m_qn, m_v, m_cnt}, {8'h00, 1'b1, 16'd0}); end
    EN = 1'b1;
    CLR_CNT = 1'b0;
    step();
    checks++; if ({m_qn, m_v, m_cnt} !== {8'h00, 1'b0, 16'd0}) begin errors++; $display("FAIL clr_after: got %h exp %h", {m_qn, m_v, m_cnt}, {8'h00, 1'b0, 16'd0}); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stall_bubble();
    test_saturation();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
